// File: rtl/core_pkg.sv
// Shared types for the 16-bit core: opcodes, instruction formats
// and the decoded-control bundle handed from decode to execute.
package core_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_ILL0  = 5'b00010;
  localparam logic [4:0] OP_ILL1  = 5'b00011;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHIFT = 5'b11010;
  localparam logic [4:0] OP_ARITH = 5'b11011;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I1,
    FMT_I2,
    FMT_J
  } fmt_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [1:0]  funct;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        useImm;
    logic        isBranch;
    logic        isJump;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction cracker: instr -> control bundle plus
// which register fields are actually read (for hazard detection).
module instr_decode
  import core_pkg::*;
#(
  parameter logic [2:0] LINK_REG = 3'd7
) (
  input  logic [15:0] instr,
  output ctrl_t       ctrl,
  output logic        readsRs,
  output logic        readsRt
);

  logic [4:0] op;
  logic isR, isAluImm, isBr, isJmp, isJr, isJ;
  logic isLd, isSt, isStu, isLbi, isSlbi, isMem, isLink;
  logic imm5s, imm5z, imm8s;
  fmt_e fmt;

  assign op       = instr[15:11];
  assign isR      = (op == OP_BTR) | (op == OP_SHIFT)
                  | (op == OP_ARITH) | (op[4:2] == 3'b111);
  assign isAluImm = (op[4:2] == 3'b010) | (op[4:2] == 3'b101);
  assign isBr     = (op[4:2] == 3'b011);
  assign isJmp    = (op[4:2] == 3'b001);
  assign isJr     = isJmp & op[0];
  assign isJ      = isJmp & ~op[0];
  assign isLd     = (op == OP_LD);
  assign isSt     = (op == OP_ST);
  assign isStu    = (op == OP_STU);
  assign isLbi    = (op == OP_LBI);
  assign isSlbi   = (op == OP_SLBI);
  assign isMem    = isLd | isSt | isStu;
  assign isLink   = (op == OP_JAL) | (op == OP_JALR);

  assign imm5s = (op[4:1] == 4'b0100) | isMem;
  assign imm5z = (op[4:1] == 4'b0101) | (op[4:2] == 3'b101);
  assign imm8s = isBr | isLbi | isJr;

  // SLBI shifts its own destination, so it reads rs too.
  assign readsRs = isR | isAluImm | isMem | isBr | isSlbi | isJr;
  assign readsRt = isR | isSt | isStu;

  always_comb begin
    fmt = FMT_J;
    unique case (1'b1)
      isR:                      fmt = FMT_R;
      isAluImm, isMem:          fmt = FMT_I1;
      isBr, isLbi, isSlbi, isJr: fmt = FMT_I2;
      default:                  fmt = FMT_J;
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.opcode = op;
    ctrl.funct  = instr[1:0];
    ctrl.rs     = instr[10:8];
    ctrl.rt     = readsRt ? instr[7:5] : 3'd0;

    unique case (1'b1)
      isR:                   ctrl.rd = instr[4:2];
      isLink:                ctrl.rd = LINK_REG;
      isLbi, isSlbi, isStu:  ctrl.rd = instr[10:8];
      isAluImm, isLd:        ctrl.rd = instr[7:5];
      default:               ctrl.rd = 3'd0;
    endcase

    unique case (1'b1)
      imm5s:   ctrl.imm = {{11{instr[4]}}, instr[4:0]};
      imm5z:   ctrl.imm = {11'd0, instr[4:0]};
      imm8s:   ctrl.imm = {{8{instr[7]}}, instr[7:0]};
      isSlbi:  ctrl.imm = {8'd0, instr[7:0]};
      isJ:     ctrl.imm = {{5{instr[10]}}, instr[10:0]};
      default: ctrl.imm = 16'd0;
    endcase

    ctrl.regWrite = isR | isAluImm | isLd | isStu
                  | isLbi | isSlbi | isLink;
    ctrl.memRead  = isLd;
    ctrl.memWrite = isSt | isStu;
    ctrl.useImm   = (fmt != FMT_R);
    ctrl.isBranch = isBr;
    ctrl.isJump   = isJmp;
    ctrl.illegal  = (op == OP_ILL0) | (op == OP_ILL1);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: valid/ready intake, load-use bubble, flush,
// sticky halt, and the registered decoded bundle toward execute.
module decode_stage
  import core_pkg::*;
#(
  parameter logic [2:0] LINK_REG = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc2,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        out_valid,
  output logic [4:0]  out_opcode,
  output logic [1:0]  out_funct,
  output logic [2:0]  out_rs,
  output logic [2:0]  out_rt,
  output logic [2:0]  out_rd,
  output logic [15:0] out_imm,
  output logic [15:0] out_pc2,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_use_imm,
  output logic        out_is_branch,
  output logic        out_is_jump,
  output logic        out_illegal,
  output logic        halted
);

  ctrl_t       dec;
  ctrl_t       outCtrl;
  logic [15:0] outPc2;
  logic        outValid, haltedQ;
  logic        readsRs, readsRt;
  logic        hazard, holdHalt, accept, transfer;

  instr_decode #(.LINK_REG(LINK_REG)) uDec (
    .instr   (in_instr),
    .ctrl    (dec),
    .readsRs (readsRs),
    .readsRt (readsRt)
  );

  // A load still sitting in the output register cannot forward
  // its data yet; stall any consumer of its destination.
  assign hazard = outValid & outCtrl.memRead & outCtrl.regWrite
                & ((readsRs & (dec.rs == outCtrl.rd))
                 | (readsRt & (dec.rt == outCtrl.rd)));

  // Nothing may enter behind a HALT.
  assign holdHalt = outValid & (outCtrl.opcode == OP_HALT);

  assign in_ready = ~rst & ~haltedQ & ~flush & ~hazard
                  & ~holdHalt & (~outValid | ex_ready);
  assign accept   = in_valid & in_ready;
  assign transfer = outValid & ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      outCtrl  <= '0;
      outPc2   <= '0;
      haltedQ  <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else begin
      if (transfer & holdHalt)
        haltedQ <= 1'b1;
      if (accept) begin
        outValid <= 1'b1;
        outCtrl  <= dec;
        outPc2   <= in_pc2;
      end else if (transfer) begin
        outValid <= 1'b0;
      end
    end
  end

  assign out_valid     = outValid;
  assign out_opcode    = outCtrl.opcode;
  assign out_funct     = outCtrl.funct;
  assign out_rs        = outCtrl.rs;
  assign out_rt        = outCtrl.rt;
  assign out_rd        = outCtrl.rd;
  assign out_imm       = outCtrl.imm;
  assign out_pc2       = outPc2;
  assign out_reg_write = outCtrl.regWrite;
  assign out_mem_read  = outCtrl.memRead;
  assign out_mem_write = outCtrl.memWrite;
  assign out_use_imm   = outCtrl.useImm;
  assign out_is_branch = outCtrl.isBranch;
  assign out_is_jump   = outCtrl.isJump;
  assign out_illegal   = outCtrl.illegal;
  assign halted        = haltedQ;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a
// randomized run against a table-driven reference decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, ex_ready;
  logic [15:0] in_instr, in_pc2;
  logic        in_ready, out_valid, halted;
  logic [4:0]  out_opcode;
  logic [1:0]  out_funct;
  logic [2:0]  out_rs, out_rt, out_rd;
  logic [15:0] out_imm, out_pc2;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        out_use_imm, out_is_branch, out_is_jump, out_illegal;
  logic [6:0]  outFlags;
  int          nChecks = 0;
  int          nFail = 0;

  always #5 clk = ~clk;

  assign outFlags = {out_reg_write, out_mem_read, out_mem_write,
                     out_use_imm, out_is_branch, out_is_jump,
                     out_illegal};

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc2(in_pc2), .flush(flush),
    .ex_ready(ex_ready), .out_valid(out_valid),
    .out_opcode(out_opcode), .out_funct(out_funct),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc2(out_pc2),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_use_imm(out_use_imm),
    .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_illegal(out_illegal), .halted(halted)
  );

  typedef struct {
    logic [15:0] imm;
    logic        immDef;
    logic [2:0]  rt, rd;
    logic        rw, mr, mw, ui, br, jp, il, rrs, rrt;
  } exp_t;

  // Reference decoder written directly from the ISA tables.
  function automatic exp_t refDecode(input logic [15:0] i);
    exp_t e;
    logic [4:0] op;
    int s5, z5, s8, z8, d11;
    op  = i[15:11];
    s5  = int'(i[4:0]) - (i[4] ? 32 : 0);
    z5  = int'(i[4:0]);
    s8  = int'(i[7:0]) - (i[7] ? 256 : 0);
    z8  = int'(i[7:0]);
    d11 = int'(i[10:0]) - (i[10] ? 2048 : 0);
    e = '{imm: 16'd0, immDef: 1'b0, rt: 3'd0, rd: 3'd0, rw: 1'b0,
          mr: 1'b0, mw: 1'b0, ui: 1'b1, br: 1'b0, jp: 1'b0,
          il: 1'b0, rrs: 1'b0, rrt: 1'b0};
    case (op) inside
      5'b00000, 5'b00001: ;
      5'b00010, 5'b00011: e.il = 1'b1;
      5'b00100: begin e.jp = 1; e.imm = 16'(d11); end
      5'b00101: begin e.jp = 1; e.rrs = 1; e.imm = 16'(s8); end
      5'b00110: begin
        e.jp = 1; e.rw = 1; e.rd = 3'd7; e.imm = 16'(d11);
      end
      5'b00111: begin
        e.jp = 1; e.rw = 1; e.rd = 3'd7; e.rrs = 1; e.imm = 16'(s8);
      end
      [5'b01000:5'b01001]: begin
        e.rw = 1; e.rrs = 1; e.rd = i[7:5]; e.imm = 16'(s5);
      end
      [5'b01010:5'b01011], [5'b10100:5'b10111]: begin
        e.rw = 1; e.rrs = 1; e.rd = i[7:5]; e.imm = 16'(z5);
      end
      [5'b01100:5'b01111]: begin
        e.br = 1; e.rrs = 1; e.imm = 16'(s8);
      end
      5'b10000: begin
        e.mw = 1; e.rrs = 1; e.rrt = 1; e.rt = i[7:5];
        e.imm = 16'(s5);
      end
      5'b10001: begin
        e.mr = 1; e.rw = 1; e.rrs = 1; e.rd = i[7:5];
        e.imm = 16'(s5);
      end
      5'b10010: begin
        e.rw = 1; e.rrs = 1; e.rd = i[10:8]; e.imm = 16'(z8);
      end
      5'b10011: begin
        e.mw = 1; e.rw = 1; e.rrs = 1; e.rrt = 1; e.rt = i[7:5];
        e.rd = i[10:8]; e.imm = 16'(s5);
      end
      5'b11000: begin e.rw = 1; e.rd = i[10:8]; e.imm = 16'(s8); end
      default: begin
        e.ui = 0; e.rw = 1; e.rrs = 1; e.rrt = 1;
        e.rt = i[7:5]; e.rd = i[4:2];
      end
    endcase
    e.immDef = e.ui && (op[4:2] != 3'b000);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1; in_valid = 0; flush = 0; ex_ready = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic issue(input logic [15:0] instr);
    in_valid = 1; in_instr = instr; in_pc2 = 16'h0102;
    ex_ready = 1; flush = 0;
    tick();
    in_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_instr = 16'h415D; in_pc2 = 16'h1234;
    ex_ready = 1; flush = 0;
    tick(); tick();
    nChecks++;
    if (in_ready !== 1'b0) begin
      nFail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    nChecks++;
    if ({out_valid, halted} !== 2'b00) begin
      nFail++;
      $display("FAIL reset_valid_halt: got %b%b expected 00",
               out_valid, halted);
    end
    nChecks++;
    if ({out_opcode, out_funct, out_rs, out_rt, out_rd, out_imm,
         out_pc2, outFlags} !== '0) begin
      nFail++;
      $display("FAIL reset_outs: got op %h imm %h pc2 %h flags %b expected 0",
               out_opcode, out_imm, out_pc2, outFlags);
    end
    rst = 0; in_valid = 0;
    tick();
  endtask

  task automatic test_addi();
    issue(16'h415D);
    nChecks++;
    if ({out_valid, out_rs, out_rd} !== {1'b1, 3'd1, 3'd2}) begin
      nFail++;
      $display("FAIL addi_regs: got v%b rs%0d rd%0d expected v1 rs1 rd2",
               out_valid, out_rs, out_rd);
    end
    nChecks++;
    if (out_imm !== 16'hFFFD) begin
      nFail++; $display("FAIL addi_imm: got %h expected fffd", out_imm);
    end
    nChecks++;
    if (outFlags !== 7'b1001000) begin
      nFail++;
      $display("FAIL addi_flags: got %b expected 1001000", outFlags);
    end
    nChecks++;
    if (out_pc2 !== 16'h0102) begin
      nFail++; $display("FAIL addi_pc2: got %h expected 0102", out_pc2);
    end
  endtask

  task automatic test_xori();
    issue(16'h515D);
    nChecks++;
    if ({out_imm, out_rd} !== {16'h001D, 3'd2}) begin
      nFail++;
      $display("FAIL xori: got imm %h rd %0d expected 001d rd 2",
               out_imm, out_rd);
    end
  endtask

  task automatic test_load_use();
    in_valid = 1; in_instr = 16'h8960; ex_ready = 1; flush = 0;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFail++; $display("FAIL lu_ld_ready: got %b expected 1", in_ready);
    end
    tick();
    in_instr = 16'hDB50;
    #1;
    nChecks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      nFail++;
      $display("FAIL lu_stall: got valid%b ready%b expected valid1 ready0",
               out_valid, in_ready);
    end
    tick();
    nChecks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      nFail++;
      $display("FAIL lu_bubble: got valid%b ready%b expected valid0 ready1",
               out_valid, in_ready);
    end
    tick();
    in_valid = 0;
    #1;
    nChecks++;
    if ({out_valid, out_rs, out_rt, out_rd} !==
        {1'b1, 3'd3, 3'd2, 3'd4}) begin
      nFail++;
      $display("FAIL lu_add: got v%b rs%0d rt%0d rd%0d expected v1 3 2 4",
               out_valid, out_rs, out_rt, out_rd);
    end
  endtask

  task automatic test_jal();
    issue(16'h37FE);
    nChecks++;
    if ({out_imm, out_rd, out_reg_write, out_is_jump} !==
        {16'hFFFE, 3'd7, 1'b1, 1'b1}) begin
      nFail++;
      $display("FAIL jal: got imm %h rd %0d rw %b jp %b expected fffe 7 1 1",
               out_imm, out_rd, out_reg_write, out_is_jump);
    end
  endtask

  task automatic test_halt();
    in_valid = 1; in_instr = 16'h0000; ex_ready = 1; flush = 0;
    tick();
    in_instr = 16'h415D;
    #1;
    nChecks++;
    if ({out_valid, out_opcode, in_ready, halted} !==
        {1'b1, 5'd0, 1'b0, 1'b0}) begin
      nFail++;
      $display("FAIL halt_held: got v%b op%h rdy%b h%b expected 1 00 0 0",
               out_valid, out_opcode, in_ready, halted);
    end
    tick();
    nChecks++;
    if (halted !== 1'b1) begin
      nFail++; $display("FAIL halt_set: got %b expected 1", halted);
    end
    for (int k = 0; k < 6; k++) begin
      nChecks++;
      if (in_ready !== 1'b0) begin
        nFail++; $display("FAIL halt_stuck: got %b expected 0", in_ready);
      end
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    #1;
    nChecks++;
    if ({halted, in_ready} !== 2'b01) begin
      nFail++;
      $display("FAIL halt_rst: got h%b rdy%b expected h0 rdy1",
               halted, in_ready);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_flush();
    doReset();
    in_valid = 1; in_instr = 16'h0000; ex_ready = 0; flush = 0;
    tick();
    in_instr = 16'h415D; flush = 1;
    #1;
    nChecks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      nFail++;
      $display("FAIL flush_pre: got v%b rdy%b expected v1 rdy0",
               out_valid, in_ready);
    end
    tick();
    flush = 0; in_valid = 0;
    #1;
    nChecks++;
    if ({out_valid, halted} !== 2'b00) begin
      nFail++;
      $display("FAIL flush_post: got v%b h%b expected 00",
               out_valid, halted);
    end
    tick();
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("FAIL flush_dropped: got v%b expected 0", out_valid);
    end
    ex_ready = 1;
  endtask

  task automatic test_random();
    logic        mValid, mHalted, expReady, haz;
    logic [15:0] mInstr, mPc;
    exp_t        h, n;
    logic [6:0]  expFlags;
    doReset();
    mValid = 0; mHalted = 0; mInstr = 0; mPc = 0;
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(3) != 0);
      do in_instr = 16'($urandom);
      while (in_instr[15:11] == 5'b00000);
      in_pc2   = 16'($urandom);
      ex_ready = ($urandom_range(3) != 0);
      flush    = ($urandom_range(15) == 0);
      #1;
      h = refDecode(mInstr);
      n = refDecode(in_instr);
      haz = mValid && h.mr && h.rw &&
            ((n.rrs && in_instr[10:8] == h.rd) ||
             (n.rrt && in_instr[7:5] == h.rd));
      expReady = !mHalted && !flush && !haz &&
                 !(mValid && mInstr[15:11] == 5'd0) &&
                 (!mValid || ex_ready);
      nChecks++;
      if ({out_valid, in_ready} !== {mValid, expReady}) begin
        nFail++;
        $display("FAIL rnd_hs c%0d: got v%b rdy%b expected v%b rdy%b",
                 c, out_valid, in_ready, mValid, expReady);
      end
      if (mValid) begin
        expFlags = {h.rw, h.mr, h.mw, h.ui, h.br, h.jp, h.il};
        nChecks++;
        if ({out_opcode, out_funct, out_rs, out_pc2, outFlags} !==
            {mInstr[15:11], mInstr[1:0], mInstr[10:8], mPc,
             expFlags}) begin
          nFail++;
          $display("FAIL rnd_fields i%h: got op%h f%0d rs%0d pc%h fl%b expected fl%b",
                   mInstr, out_opcode, out_funct, out_rs, out_pc2,
                   outFlags, expFlags);
        end
        if (h.rw) begin
          nChecks++;
          if (out_rd !== h.rd) begin
            nFail++;
            $display("FAIL rnd_rd i%h: got %0d expected %0d",
                     mInstr, out_rd, h.rd);
          end
        end
        if (h.rrt) begin
          nChecks++;
          if (out_rt !== h.rt) begin
            nFail++;
            $display("FAIL rnd_rt i%h: got %0d expected %0d",
                     mInstr, out_rt, h.rt);
          end
        end
        if (h.immDef) begin
          nChecks++;
          if (out_imm !== h.imm) begin
            nFail++;
            $display("FAIL rnd_imm i%h: got %h expected %h",
                     mInstr, out_imm, h.imm);
          end
        end
      end
      @(posedge clk);
      if (flush) begin
        mValid = 0;
      end else begin
        if (mValid && ex_ready && mInstr[15:11] == 5'd0) mHalted = 1;
        if (in_valid && expReady) begin
          mValid = 1; mInstr = in_instr; mPc = in_pc2;
        end else if (mValid && ex_ready) begin
          mValid = 0;
        end
      end
      #1;
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; in_instr = 0; in_pc2 = 0;
    flush = 0; ex_ready = 1;
    test_reset();
    test_addi();
    test_xori();
    test_load_use();
    test_jal();
    test_halt();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode pipeline stage for the 16-bit core.
- Accepts fetched instructions over a valid/ready handshake and cracks them into the 5-bit opcode, the 2-bit funct, register indices, an extended immediate and control flags that drive the execute-stage ALU.
- Holds the decoded result in an output pipeline register with downstream backpressure.
- Inserts load-use bubbles, honours flush from branch resolution, and stops on HALT.

Parameters:
- LINK_REG, 3'd7, destination register for JAL/JALR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- in_instr  in  16  instruction word.
- in_pc2  in  16  PC+2 of the instruction.
- flush  in  1  kill the held entry and the incoming entry.
- ex_ready  in  1  execute stage accepts the output this cycle.
- out_valid  out  1  output register holds a live instruction.
- out_opcode  out  5  instr[15:11].
- out_funct  out  2  instr[1:0].
- out_rs, out_rt, out_rd  out  3 each  source and destination indices.
- out_imm  out  16  extended immediate.
- out_pc2  out  16  registered in_pc2.
- out_reg_write, out_mem_read, out_mem_write, out_use_imm, out_is_branch, out_is_jump, out_illegal  out  1 each  control flags.
- halted  out  1  sticky halt status.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: every out_* is 0, out_valid=0, halted=0; in_ready=0 while rst is high.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Transfer = out_valid & ex_ready.
  - Output register holds its value while out_valid & ~ex_ready.
- in_ready = ~rst & ~halted & ~flush & ~hazard & ~hold_halt & (~out_valid | ex_ready).
  - hold_halt = out_valid & (out_opcode==00000).
- Load-use hazard:
  - hazard = out_valid & out_mem_read & out_reg_write & ((reads_rs(in) & rs(in)==out_rd) | (reads_rt(in) & rt(in)==out_rd)).
  - On hazard & ex_ready: out_valid becomes 0 next cycle (one bubble) and the incoming instruction is held. It is accepted the following cycle.
- Flush: highest priority. Next cycle out_valid=0, the incoming instruction is discarded, and halted is not set.
- halted: set when a HALT transfers while flush is low. It clears only on rst.
- Field extraction:
  - out_rs = instr[10:8].
  - R-type (11011, 11010, 111xx, 11001): rt = [7:5], rd = [4:2].
  - I-format1 (010xx, 101xx, 100xx): rd = [7:5].
  - Stores 10000/10011 read [7:5] as rt. STU writes rd = rs.
  - LBI/SLBI: rd = [10:8].
  - JAL/JALR: rd = LINK_REG.
- Immediates:
  - Sign-extended imm5: ADDI/SUBI (0100x), ST/LD/STU.
  - Zero-extended imm5: 0101x, 101xx.
  - Sign-extended imm8: 011xx, LBI, JR/JALR (001x1).
  - Zero-extended imm8: SLBI.
  - Sign-extended disp11: J/JAL (001x0).
- Flags:
  - reg_write: ALU, imm, LD, STU, LBI, SLBI, JAL, JALR.
  - mem_read: LD.
  - mem_write: ST, STU.
  - is_branch: 011xx.
  - is_jump: 001xx.
  - use_imm: every non-R-type.
- Illegal opcodes 00010, 00011, 11010/11011 with unused encodings do not exist. Opcodes 00010/00011 decode to out_illegal=1 with all write/mem flags 0. They otherwise pass as a NOP.
- HALT (00000) and NOP (00001) have all write/mem flags 0.

Decomposition:
- Shared package (core_pkg):
  - 5-bit opcode constants.
  - Instruction-format enum (R, I1, I2, J).
  - Decoded-control struct.
- One combinational sub-module, instr_decode: instr -> control struct, reads_rs, reads_rt.
- decode_stage owns the handshake, hazard, flush, halt and output register.

Test Plan:
- ADDI 0x415D accepted, ex_ready=1 -> next cycle out_valid=1, rs=1, rd=2, imm=0xFFFD, reg_write=1, use_imm=1.
- XORI 0x515D -> imm=0x001D (zero-extended), rd=2.
- LD 0x8960 followed by ADD 0xDB50 with continuous in_valid and ex_ready:
  - in_ready=0 for one cycle.
  - out_valid sequence is 1,0,1.
  - ADD decodes rs=3, rt=2, rd=4.
- JAL 0x37FE -> imm=0xFFFE, rd=7, reg_write=1, is_jump=1.
- HALT 0x0000 then in_valid held with 0x415D:
  - halted=1 the cycle after HALT transfers.
  - in_ready stays 0 indefinitely.
  - rst clears both.
- Flush while out_valid=1, ex_ready=0, in_valid=1 -> out_valid=0 next cycle, incoming not consumed, halted=0 even if the held entry was HALT.
